// File: rtl/pe_pkg.sv
// Shared definitions for the 4-lane 4-bit dot-product PE and its sequencer.
package pe_pkg;
  localparam int PE_LANES   = 4;
  localparam int PE_ELEM_W  = 4;
  localparam int PE_OUT_W   = 10;
  localparam int PE_MAX_DOT = 900;
  localparam int PE_OP_W    = PE_LANES * PE_ELEM_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/pe_dot_seq_if.sv
// Command / operand / result handshake bundle between the CFU front end and pe_dot_seq.
interface pe_dot_seq_if #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 18
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [LEN_W-1:0]            cmd_len;
  logic                        op_valid;
  logic                        op_ready;
  logic [pe_pkg::PE_OP_W-1:0]  op_a;
  logic [pe_pkg::PE_OP_W-1:0]  op_b;
  logic                        abort;
  logic                        res_valid;
  logic                        res_ready;
  logic [ACC_W-1:0]            res_data;
  logic                        busy;

  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, abort, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, abort, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, busy
  );
endinterface

// File: rtl/pe_dot_seq_pe.sv
// Combinational dot-product PE: one multiplier per lane, summed into PE_OUT_W bits.
module pe_lane_mul #(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0]   a,
  input  logic [VEC_W-1:0]   b,
  output logic [2*VEC_W-1:0] p
);
  assign p = a * b;
endmodule

module pe_dot_seq_pe import pe_pkg::*; #(
  parameter int NUM_LANES = PE_LANES,
  parameter int VEC_W     = PE_ELEM_W,
  parameter int OUT_W     = PE_OUT_W
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] in_a,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] in_b,
  output logic [OUT_W-1:0]                out_c
);
  logic [NUM_LANES-1:0][2*VEC_W-1:0] prod;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pe_lane_mul #(.VEC_W(VEC_W)) u_mul (
      .a (in_a[i]),
      .b (in_b[i]),
      .p (prod[i])
    );
  end

  always_comb begin
    out_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      out_c = out_c + OUT_W'(prod[i]);
  end
endmodule

// File: rtl/pe_dot_seq.sv
// Streams LEN operand pairs through the PE and accumulates the dot products into one sum.
module pe_dot_seq import pe_pkg::*; #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_dot_seq_if.slave  bus
);
  state_t              state;
  logic [LEN_W-1:0]    remaining;
  logic [PE_OUT_W-1:0] pe_out;
  logic [PE_OUT_W-1:0] p_reg;
  logic                p_vld;
  logic [ACC_W-1:0]    acc;
  logic                cmd_ready_q, op_ready_q, res_valid_q, busy_q;
  logic                cmd_hs, op_hs, res_hs, abort_act;

  assign cmd_hs    = bus.cmd_valid & cmd_ready_q;
  assign op_hs     = bus.op_valid  & op_ready_q;
  assign res_hs    = bus.res_ready & res_valid_q;
  assign abort_act = bus.abort & (state != IDLE);

  pe_dot_seq_pe #(.NUM_LANES(PE_LANES), .VEC_W(PE_ELEM_W), .OUT_W(PE_OUT_W)) u_pe (
    .in_a  (bus.op_a),
    .in_b  (bus.op_b),
    .out_c (pe_out)
  );

  // Handshake outputs are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      p_reg       <= '0;
      p_vld       <= 1'b0;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      p_vld <= 1'b0;
      if (abort_act) begin
        state       <= IDLE;
        remaining   <= '0;
        cmd_ready_q <= 1'b1;
        op_ready_q  <= 1'b0;
        res_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cmd_hs) begin
            remaining   <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_len != '0) begin
              state      <= RUN;
              op_ready_q <= 1'b1;
            end else begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end
          end
          RUN: if (op_hs) begin
            p_reg     <= pe_out;
            p_vld     <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state      <= DRAIN;
              op_ready_q <= 1'b0;
            end
          end
          DRAIN: begin
            state       <= DONE;
            res_valid_q <= 1'b1;
          end
          DONE: if (res_hs) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Accumulates whenever a product is pending, regardless of state; p_vld is
  // already clear in DONE, so the result holds without an extra enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (abort_act || cmd_hs)
      acc <= '0;
    else if (p_vld)
      acc <= acc + ACC_W'(p_reg);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pe_dot_seq.sv
// Directed bench for pe_dot_seq: single-pair vector table plus multi-cycle corner sequences.
module tb_pe_dot_seq;
  localparam int LEN_W = 8;
  localparam int ACC_W = 18;

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [ACC_W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_dot_seq_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

  pe_dot_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from qa/qb; lat counts cycles from the last accepting edge to res_valid.
  task automatic do_job(input int len, input int gap, input int rdelay, input bit chk_stall,
                        input logic [ACC_W-1:0] exp, output logic [ACC_W-1:0] res, output int lat);
    int guard;
    int stalls;
    logic [31:0] len_v;
    len_v = len;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len_v[LEN_W-1:0];
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin tick(); guard++; end
    if (guard >= 50) chk("cmd_timeout", 32'd0, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin bus.op_valid = 1'b0; tick(); end
      bus.op_valid = 1'b1;
      bus.op_a     = qa[i];
      bus.op_b     = qb[i];
      guard = 0;
      while (!bus.op_ready && guard < 50) begin tick(); guard++; stalls++; end
      if (guard >= 50) chk("op_timeout", 32'd0, 32'd1);
      tick();
    end
    bus.op_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 50) begin tick(); lat++; end
    if (lat >= 50) chk("res_timeout", 32'd0, 32'd1);
    if (chk_stall) chk("op_stalls", 32'(stalls), 32'd0);
    for (int r = 0; r < rdelay; r++) begin
      chk("res_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("res_hold_data", 32'(bus.res_data), 32'(exp));
      tick();
    end
    bus.res_ready = 1'b1;
    res = bus.res_data;
    tick();
    bus.res_ready = 1'b0;
    chk("cmd_ready_after_res", 32'(bus.cmd_ready), 32'd1);
    chk("res_valid_after_res", 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    logic [ACC_W-1:0] res;
    int lat;

    vecs[0] = '{16'h4321, 16'h1111, 18'd10};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 18'd900};
    vecs[2] = '{16'h0000, 16'hFFFF, 18'd0};
    vecs[3] = '{16'h0002, 16'h0003, 18'd6};
    vecs[4] = '{16'h1234, 16'h4321, 18'd20};
    vecs[5] = '{16'hF0F0, 16'h0F0F, 18'd0};
    vecs[6] = '{16'h8421, 16'h1248, 18'd32};

    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.op_valid = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.abort = 1'b0; bus.res_ready = 1'b0;

    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_op_ready",  32'(bus.op_ready),  32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      qa = {vecs[k].a};
      qb = {vecs[k].b};
      do_job(1, 0, 0, 1'b0, vecs[k].exp, res, lat);
      chk($sformatf("vec%0d_res", k), 32'(res), 32'(vecs[k].exp));
      chk($sformatf("vec%0d_lat", k), 32'(lat), 32'd2);
    end

    // Full-length job streaming back to back at the largest per-pair product.
    qa.delete(); qb.delete();
    for (int i = 0; i < 255; i++) begin qa.push_back(16'hFFFF); qb.push_back(16'hFFFF); end
    do_job(255, 0, 0, 1'b1, 18'd229500, res, lat);
    chk("len255_res", 32'(res), 32'd229500);
    chk("len255_lat", 32'(lat), 32'd2);

    // Zero-length command goes straight to DONE.
    bus.cmd_valid = 1'b1; bus.cmd_len = '0;
    tick();
    bus.cmd_valid = 1'b0;
    chk("len0_res_valid", 32'(bus.res_valid), 32'd1);
    chk("len0_op_ready",  32'(bus.op_ready),  32'd0);
    chk("len0_res_data",  32'(bus.res_data),  32'd0);
    chk("len0_busy",      32'(bus.busy),      32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("len0_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Gapped operands and a slow result consumer.
    qa = {16'h0001, 16'h0020, 16'h5000};
    qb = {16'h000F, 16'h0030, 16'h2000};
    do_job(3, 2, 5, 1'b0, 18'd31, res, lat);
    chk("gap_res", 32'(res), 32'd31);
    chk("gap_lat", 32'(lat), 32'd2);

    // Abort coinciding with the third operand handshake.
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4;
    tick();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 16'h0001; bus.op_b = 16'h0001;
    tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0; bus.op_valid = 1'b0;
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_op_ready",  32'(bus.op_ready),  32'd0);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_res", 32'(bus.res_valid), 32'd0);
      tick();
    end
    qa = {16'h0002}; qb = {16'h0003};
    do_job(1, 0, 0, 1'b0, 18'd6, res, lat);
    chk("post_abort_res", 32'(res), 32'd6);

    // Abort while a result is pending in DONE.
    qa = {16'h4321}; qb = {16'h1111};
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = qa[0]; bus.op_b = qb[0];
    tick();
    bus.op_valid = 1'b0;
    tick();
    chk("done_res_valid", 32'(bus.res_valid), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("done_abort_res_valid", 32'(bus.res_valid), 32'd0);
    chk("done_abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Asynchronous reset in the middle of RUN.
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4;
    tick();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 16'hFFFF; bus.op_b = 16'hFFFF;
    tick(); tick();
    bus.op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("arst_op_ready",  32'(bus.op_ready),  32'd0);
    chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_res_data",  32'(bus.res_data),  32'd0);
    chk("arst_busy",      32'(bus.busy),      32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("arst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    qa = {16'h4321}; qb = {16'h1111};
    do_job(1, 0, 0, 1'b0, 18'd10, res, lat);
    chk("post_rst_res", 32'(res), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
